// File: rtl/fifo_word_unpacker_if.sv
// Handshake bundle between the FWFT FIFO read port, the word unpacker and the byte sink.
// The unpacker owns the master side; the FIFO/sink environment owns the slave side.
interface fifo_word_unpacker_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
);
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;

  modport master (
    input  fifo_data, fifo_empty, tx_ready,
    output fifo_pop, tx_data, tx_valid, tx_last
  );

  modport slave (
    output fifo_data, fifo_empty, tx_ready,
    input  fifo_pop, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Pops words from an FWFT FIFO and streams them out as bytes over valid/ready,
// flagging the last byte of every FRAME_WORDS-word frame.
module fifo_word_unpacker #(
  parameter int DATA_W      = 32,
  parameter int BYTE_W      = 8,
  parameter bit MSB_FIRST   = 1'b0,
  parameter int FRAME_WORDS = 1024,
  localparam int CNT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_word_unpacker_if.master bus,
  output logic                 frame_done,
  output logic                 busy,
  output logic [CNT_W-1:0]     word_cnt
);
  localparam int BYTES = DATA_W / BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [DATA_W-1:0]  word_r, word_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               fd_r, fd_s;
  logic               pop_s;
  logic               valid_s;
  logic               last_byte_s;
  logic               last_s;
  logic               hs_s;
  logic [IDX_W-1:0]   slot_s;

  // Output decode; rst blanks everything combinationally so the reset cycle itself is quiet.
  always_comb begin
    valid_s     = (state_r == SEND) && !rst;
    last_byte_s = (idx_r == LAST_IDX);
    last_s      = valid_s && last_byte_s && (cnt_r == LAST_CNT);
    hs_s        = valid_s && bus.tx_ready;
    slot_s      = MSB_FIRST ? (LAST_IDX - idx_r) : idx_r;
  end

  assign bus.tx_valid = valid_s;
  assign bus.tx_last  = last_s;
  assign bus.tx_data  = valid_s ? word_r[int'(slot_s)*BYTE_W +: BYTE_W] : {BYTE_W{1'b0}};
  assign bus.fifo_pop = pop_s && !bus.fifo_empty && !rst;
  assign busy         = valid_s;
  assign frame_done   = fd_r;
  assign word_cnt     = cnt_r;

  // Next-state logic: the last-byte handshake reloads straight from the FIFO to avoid a bubble.
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    fd_s    = 1'b0;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!bus.fifo_empty) begin
          pop_s   = 1'b1;
          word_s  = bus.fifo_data;
          idx_s   = {IDX_W{1'b0}};
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (hs_s && last_byte_s) begin
          fd_s  = last_s;
          cnt_s = (cnt_r == LAST_CNT) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
          if (!bus.fifo_empty) begin
            pop_s  = 1'b1;
            word_s = bus.fifo_data;
            idx_s  = {IDX_W{1'b0}};
          end else begin
            state_s = IDLE;
          end
        end else if (hs_s) begin
          idx_s = idx_r + IDX_W'(1);
        end else begin
          idx_s = idx_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a partly sent word is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      word_r  <= {DATA_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      fd_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      fd_r    <= fd_s;
    end
  end
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Self-checking bench: an LSB-first and an MSB-first unpacker (both 2-word frames) share
// one FIFO model and one sink, run through a vector table plus multi-cycle sequences.
module tb_fifo_word_unpacker;
  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [5:0] rd_ptr = 6'd0;
  logic [5:0] wr_ptr = 6'd0;
  logic [31:0] mem [64];
  int         pop_cnt = 0;
  int         errors = 0;
  int         checks = 0;
  logic       exp_wc;

  logic       fd_a, fd_b, busy_a, busy_b;
  logic [0:0] wc_a, wc_b;

  fifo_word_unpacker_if #(.DATA_W(32), .BYTE_W(8)) ifa ();
  fifo_word_unpacker_if #(.DATA_W(32), .BYTE_W(8)) ifb ();

  assign ifa.fifo_data  = mem[rd_ptr];
  assign ifb.fifo_data  = mem[rd_ptr];
  assign ifa.fifo_empty = (rd_ptr == wr_ptr);
  assign ifb.fifo_empty = (rd_ptr == wr_ptr);
  assign ifa.tx_ready   = rdy;
  assign ifb.tx_ready   = rdy;

  fifo_word_unpacker #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b0), .FRAME_WORDS(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .frame_done(fd_a), .busy(busy_a), .word_cnt(wc_a));
  fifo_word_unpacker #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1'b1), .FRAME_WORDS(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .frame_done(fd_b), .busy(busy_b), .word_cnt(wc_b));

  always #5 clk = ~clk;

  // FIFO read side follows dut_a's pop strobe
  always @(posedge clk) begin
    if (ifa.fifo_pop) begin
      rd_ptr  <= rd_ptr + 6'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        push;
    logic [31:0] word;
    logic        pop;
    logic        valid;
    logic [7:0]  da;
    logic [7:0]  db;
    logic        last;
    logic        fd;
    logic        cnt;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic stream(input logic [31:0] w [8], input int n, input bit do_push, input bit rnd);
    int   total = n * 4;
    int   got = 0;
    int   pos = 0;
    int   wi = 0;
    int   cyc = 0;
    int   pops0 = pop_cnt;
    bit   started = 1'b0;
    bit   prev_stall = 1'b0;
    bit   prev_hs_last = 1'b0;
    bit   hs;
    logic exp_last;
    logic [7:0] prev_a = 8'h00;
    logic [7:0] prev_b = 8'h00;
    logic [31:0] wd;
    if (do_push) begin
      for (int i = 0; i < n; i++) push(w[i]);
    end
    while (got < total && cyc < 400) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("frame_done_a", fd_a, prev_hs_last);
      check("frame_done_b", fd_b, prev_hs_last);
      check("word_cnt", wc_a, exp_wc);
      check("pop_b", ifb.fifo_pop, ifa.fifo_pop);
      if (!rnd && started) check("no_gap", ifa.tx_valid, 1'b1);
      if (prev_stall) begin
        check("stall_valid", ifa.tx_valid, 1'b1);
        check("stall_data_a", ifa.tx_data, prev_a);
        check("stall_data_b", ifb.tx_data, prev_b);
      end
      hs = ifa.tx_valid && rdy;
      if (ifa.fifo_pop && ifa.tx_valid) check("pop_on_last", (hs && pos == 3), 1'b1);
      exp_last = (pos == 3) && (exp_wc == 1'b1);
      if (ifa.tx_valid) begin
        started = 1'b1;
        check("tx_last", ifa.tx_last, exp_last);
      end
      if (hs) begin
        wd = w[wi];
        check("byte_lsb", ifa.tx_data, wd[8*pos +: 8]);
        check("byte_msb", ifb.tx_data, wd[8*(3-pos) +: 8]);
        got++;
        prev_hs_last = exp_last;
        if (pos == 3) begin
          pos = 0;
          wi++;
          exp_wc = ~exp_wc;
        end else begin
          pos++;
        end
      end else begin
        prev_hs_last = 1'b0;
      end
      prev_stall = ifa.tx_valid && !rdy;
      prev_a = ifa.tx_data;
      prev_b = ifb.tx_data;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("stream_bytes", got, total);
    rdy = 1'b1;
    #1;
    check("end_valid", ifa.tx_valid, 1'b0);
    check("end_fd", fd_a, prev_hs_last);
    check("pop_count", pop_cnt - pops0, n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w [8];
    rst = 1'b1;
    rdy = 1'b0;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'hAA, 8'hDD, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'hBB, 8'hCC, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'hCC, 8'hBB, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'hDD, 8'hAA, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h44332211, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h11, 8'h44, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h22, 8'h33, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h33, 8'h22, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h44, 8'h11, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h87654321, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'h21, 8'h87, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h21, 8'h87, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h43, 8'h65, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 8'h65, 8'h43, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h65, 8'h43, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 8'h87, 8'h21, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst;
      rdy = tbl[i].rdy;
      if (tbl[i].push) push(tbl[i].word);
      #1;
      check($sformatf("v%0d_pop", i),   ifa.fifo_pop, tbl[i].pop);
      check($sformatf("v%0d_pop_b", i), ifb.fifo_pop, tbl[i].pop);
      check($sformatf("v%0d_valid", i), ifa.tx_valid, tbl[i].valid);
      check($sformatf("v%0d_busy", i),  busy_b,       tbl[i].valid);
      check($sformatf("v%0d_da", i),    ifa.tx_data,  tbl[i].da);
      check($sformatf("v%0d_db", i),    ifb.tx_data,  tbl[i].db);
      check($sformatf("v%0d_last", i),  ifa.tx_last,  tbl[i].last);
      check($sformatf("v%0d_fd", i),    fd_a,         tbl[i].fd);
      check($sformatf("v%0d_cnt", i),   wc_a,         tbl[i].cnt);
      @(posedge clk);
      #1;
    end
    exp_wc = 1'b1;

    // back-to-back: three words, sink always ready
    w = '{32'h0D0C0B0A, 32'h1D1C1B1A, 32'h2D2C2B2A, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    stream(w, 3, 1'b1, 1'b0);

    // random backpressure over eight words
    w = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0,
          32'hE3E2E1E0, 32'hF3F2F1F0, 32'h03020100, 32'h13121110};
    stream(w, 8, 1'b1, 1'b1);

    // reset in the middle of 0x44332211
    rdy = 1'b1;
    push(32'h44332211);
    #1;
    check("rst_seq_pop", ifa.fifo_pop, 1'b1);
    @(posedge clk); #1;
    check("rst_seq_b0", ifa.tx_data, 8'h11);
    @(posedge clk); #1;
    check("rst_seq_b1", ifa.tx_data, 8'h22);
    @(posedge clk); #1;
    rst = 1'b1;
    push(32'h88776655);
    #1;
    check("rst_valid",  ifa.tx_valid, 1'b0);
    check("rst_data_a", ifa.tx_data,  8'h00);
    check("rst_data_b", ifb.tx_data,  8'h00);
    check("rst_last",   ifa.tx_last,  1'b0);
    check("rst_pop",    ifa.fifo_pop, 1'b0);
    check("rst_busy",   busy_a,       1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wc = 1'b0;
    w = '{32'h88776655, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    stream(w, 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
